ex_resolve: RTL and testbench
=============================

Name: ex_resolve

Overview:
- Consumer end of the ALU interface: registers ALU result plus flags (zero/carry/negative/overflow) into the EX/MEM pipeline register.
- Resolves conditional branches from the flags and drives the fetch redirect.
- Raises the MIPS arithmetic-overflow trap for signed add/sub.
- Sits between the ALU/EX stage and the MEM stage of the pipelined CPU.

Parameters:
- DW, 32, datapath width (result, store data, PC)
- RW, 5, register-index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EX stage holds a valid instruction
- in_ready  out  1  block can accept this cycle
- flush  in  1  squash the EX/MEM register contents (from exception/control unit)
- pc  in  DW  address of the EX-stage instruction
- br_target  in  DW  precomputed branch target
- br_type  in  3  branch kind (see package)
- aluc  in  4  ALU control code of the instruction
- alu_r  in  DW  ALU result
- alu_zero, alu_carry, alu_negative, alu_overflow  in  1 each  ALU flags
- st_data  in  DW  store data
- rd  in  RW  destination register
- wreg, m2reg, wmem  in  1 each  control bits
- out_valid  out  1  EX/MEM register valid
- out_ready  in  1  MEM stage accepts
- out_r, out_st_data  out  DW  registered result and store data
- out_rd  out  RW
- out_wreg, out_m2reg, out_wmem  out  1 each
- redirect  out  1  one-cycle taken-branch pulse
- redirect_pc  out  DW  target that accompanies redirect
- exc_ovf  out  1  overflow exception pending
- exc_epc  out  DW  PC of the trapping instruction
- exc_ack  in  1  exception handler has taken the trap

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, all out_* data=0, redirect=0, redirect_pc=0, exc_ovf=0, exc_epc=0, state=RUN. Reset takes effect mid-operation and overrides everything else.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Accept condition: in_valid && in_ready && !flush. An accepted instruction appears on out_* the next cycle (latency 1).
- Output register: holds its contents while out_valid && !out_ready.
  - It clears to invalid when consumed with no new accept.
  - When an accept coincides with consumption, the new entry is loaded that cycle.
- br_type codes: 000 none, 001 beq (taken if alu_zero), 010 bne (!alu_zero), 011 bgez (!alu_negative), 100 bltz (alu_negative), 101 blez (alu_negative||alu_zero), 110 bgtz (!alu_negative&&!alu_zero), 111 reserved (never taken).
- Comparisons use the subtraction flags, with the ALU computing a-b for beq/bne and a-0 otherwise.
- On accept with a taken branch: redirect=1 and redirect_pc=br_target on the next cycle, for exactly one cycle. The branch's entry still goes downstream, with out_wreg as given.
- The delay-slot instruction is not squashed here.
- redirect is 0 in every other cycle.
- flush: out_valid cleared next cycle, no accept, redirect forced 0. flush has priority over out_ready and accept. It does not clear exc_ovf; only exc_ack clears exc_ovf.
- States: RUN and TRAP. TRAP exists only with the optional feature.
- Flags alu_carry and alu_overflow are not used for branches. Width: all data passes unmodified, with no sign or zero extension.

Optional Feature:
- Macro: MIPS246_EXC_OVF_EN.
- Defined, trap case: on accept with aluc==4'b0010 (add) or 4'b0011 (sub) and alu_overflow=1:
  - The entry is loaded with out_wreg=0, out_wmem=0, out_m2reg=0.
  - exc_ovf=1 and exc_epc=pc.
  - state moves to TRAP and redirect is not asserted.
- Defined, TRAP state: in_ready=0. exc_ack → RUN with exc_ovf=0 next cycle. exc_ack in RUN is ignored.
- Defined, simultaneous events: exc_ack in the same cycle as a new trap is not possible, since there is no accept in TRAP.
- Not defined: alu_overflow is ignored, add/sub write rd like addu/subu, exc_ovf and exc_epc are tied to 0, and the state register is omitted.

Decomposition:
- Package mips246_ex_pkg holds:
  - aluc localparams: ALUC_ADDU=0000, SUBU=0001, ADD=0010, SUB=0011, AND=0100, OR=0101, XOR=0110, NOR=0111, LUI=1000, SLT=1010, SLTU=1011, SLL=1111, SRL=1101, SRA=1100.
  - br_type codes.
  - RUN/TRAP state encoding.
- Sub-module br_cond: combinational taking br_type and the zero/negative flags, producing taken.

Test Plan:
- Reset while out_valid=1 with redirect pending → next cycle all outputs 0, in_ready=1.
- beq with alu_zero=1, br_target=0x00400020 → redirect=1 and redirect_pc=0x00400020 for exactly one cycle; out_valid=1. bne with the same flags → redirect stays 0.
- bltz/blez/bgtz sweep over (neg,zero) ∈ {(0,0),(0,1),(1,0)} → taken only for 1/0, 1/0 or 0/1, and 0/0 respectively.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_r held at 0x12345678. Release → next entry loaded on the first cycle with out_ready=1.
- flush in the same cycle as an accepted taken branch → out_valid=0 next cycle, redirect=0.
- With MIPS246_EXC_OVF_EN: add with alu_overflow=1, pc=0x00400100 → exc_ovf=1, exc_epc=0x00400100, out_wreg=0, in_ready=0 until exc_ack. Then exc_ovf=0 and in_ready=1. The same stimulus without the macro → out_wreg=1, exc_ovf=0.

Source files
------------

// File: rtl/mips246_ex_pkg.sv
// Shared encodings for the EX-stage resolve block: ALU control codes, branch kinds, FSM states.
package mips246_ex_pkg;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_LUI  = 4'b1000;
  localparam logic [3:0] ALUC_SLT  = 4'b1010;
  localparam logic [3:0] ALUC_SLTU = 4'b1011;
  localparam logic [3:0] ALUC_SLL  = 4'b1111;
  localparam logic [3:0] ALUC_SRL  = 4'b1101;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BGEZ = 3'b011,
    BR_BLTZ = 3'b100,
    BR_BLEZ = 3'b101,
    BR_BGTZ = 3'b110,
    BR_RSVD = 3'b111
  } br_type_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  // Only the signed add/sub forms raise the overflow trap.
  function automatic logic is_ovf_op(input logic [3:0] code);
    return (code == ALUC_ADD) || (code == ALUC_SUB);
  endfunction

endpackage

// File: rtl/ex_resolve_br_cond.sv
// Branch condition evaluation from the subtraction flags (zero/negative only).
module br_cond
  import mips246_ex_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       zero,
  input  logic       negative,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_type_e'(br_type))
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = !zero;
      BR_BGEZ: taken = !negative;
      BR_BLTZ: taken = negative;
      BR_BLEZ: taken = negative || zero;
      BR_BGTZ: taken = !negative && !zero;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_resolve.sv
// EX/MEM pipeline register with branch resolution and fetch redirect.
// Optional MIPS overflow trap enabled by defining MIPS246_EXC_OVF_EN.
module ex_resolve
  import mips246_ex_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] br_target,
  input  logic [2:0]    br_type,
  input  logic [3:0]    aluc,
  input  logic [DW-1:0] alu_r,
  input  logic          alu_zero,
  input  logic          alu_carry,
  input  logic          alu_negative,
  input  logic          alu_overflow,
  input  logic [DW-1:0] st_data,
  input  logic [RW-1:0] rd,
  input  logic          wreg,
  input  logic          m2reg,
  input  logic          wmem,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_st_data,
  output logic [RW-1:0] out_rd,
  output logic          out_wreg,
  output logic          out_m2reg,
  output logic          out_wmem,
  output logic          redirect,
  output logic [DW-1:0] redirect_pc,
  output logic          exc_ovf,
  output logic [DW-1:0] exc_epc,
  input  logic          exc_ack
);

  logic run;
  logic trap_hit;
  logic taken;
  logic accept;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_r_q, out_r_d;
  logic [DW-1:0] out_st_q, out_st_d;
  logic [RW-1:0] out_rd_q, out_rd_d;
  logic          out_wreg_q, out_wreg_d;
  logic          out_m2reg_q, out_m2reg_d;
  logic          out_wmem_q, out_wmem_d;
  logic          redirect_q, redirect_d;
  logic [DW-1:0] redirect_pc_q, redirect_pc_d;

  br_cond u_br_cond (
    .br_type  (br_type),
    .zero     (alu_zero),
    .negative (alu_negative),
    .taken    (taken)
  );

  assign in_ready = run && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

`ifdef MIPS246_EXC_OVF_EN
  state_e        state_q, state_d;
  logic          exc_ovf_q, exc_ovf_d;
  logic [DW-1:0] exc_epc_q, exc_epc_d;

  assign run      = (state_q == ST_RUN);
  assign trap_hit = is_ovf_op(aluc) && alu_overflow;

  always_comb begin
    state_d   = state_q;
    exc_ovf_d = exc_ovf_q;
    exc_epc_d = exc_epc_q;
    case (state_q)
      ST_RUN: begin
        if (accept && trap_hit) begin
          state_d   = ST_TRAP;
          exc_ovf_d = 1'b1;
          exc_epc_d = pc;
        end
      end
      ST_TRAP: begin
        if (exc_ack) begin
          state_d   = ST_RUN;
          exc_ovf_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      exc_ovf_q <= 1'b0;
      exc_epc_q <= '0;
    end else begin
      state_q   <= state_d;
      exc_ovf_q <= exc_ovf_d;
      exc_epc_q <= exc_epc_d;
    end
  end

  assign exc_ovf = exc_ovf_q;
  assign exc_epc = exc_epc_q;

  logic unused_inputs;
  assign unused_inputs = alu_carry;
`else
  assign run      = 1'b1;
  assign trap_hit = 1'b0;
  assign exc_ovf  = 1'b0;
  assign exc_epc  = '0;

  logic unused_inputs;
  assign unused_inputs = ^{alu_carry, alu_overflow, aluc, exc_ack};
`endif

  // flush outranks accept and consumption; redirect is a single-cycle pulse.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_r_d       = out_r_q;
    out_st_d      = out_st_q;
    out_rd_d      = out_rd_q;
    out_wreg_d    = out_wreg_q;
    out_m2reg_d   = out_m2reg_q;
    out_wmem_d    = out_wmem_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_r_d     = alu_r;
      out_st_d    = st_data;
      out_rd_d    = rd;
      out_wreg_d  = wreg && !trap_hit;
      out_m2reg_d = m2reg && !trap_hit;
      out_wmem_d  = wmem && !trap_hit;
      if (taken && !trap_hit) begin
        redirect_d    = 1'b1;
        redirect_pc_d = br_target;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_r_q       <= '0;
      out_st_q      <= '0;
      out_rd_q      <= '0;
      out_wreg_q    <= 1'b0;
      out_m2reg_q   <= 1'b0;
      out_wmem_q    <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_r_q       <= out_r_d;
      out_st_q      <= out_st_d;
      out_rd_q      <= out_rd_d;
      out_wreg_q    <= out_wreg_d;
      out_m2reg_q   <= out_m2reg_d;
      out_wmem_q    <= out_wmem_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_r       = out_r_q;
  assign out_st_data = out_st_q;
  assign out_rd      = out_rd_q;
  assign out_wreg    = out_wreg_q;
  assign out_m2reg   = out_m2reg_q;
  assign out_wmem    = out_wmem_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ex_resolve.sv
// Directed self-checking bench for ex_resolve; expectations follow MIPS246_EXC_OVF_EN if defined.
module tb_ex_resolve;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [DW-1:0] pc;
  logic [DW-1:0] br_target;
  logic [2:0]    br_type;
  logic [3:0]    aluc;
  logic [DW-1:0] alu_r;
  logic          alu_zero, alu_carry, alu_negative, alu_overflow;
  logic [DW-1:0] st_data;
  logic [RW-1:0] rd;
  logic          wreg, m2reg, wmem;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r, out_st_data;
  logic [RW-1:0] out_rd;
  logic          out_wreg, out_m2reg, out_wmem;
  logic          redirect;
  logic [DW-1:0] redirect_pc;
  logic          exc_ovf;
  logic [DW-1:0] exc_epc;
  logic          exc_ack;

  int total;
  int bad;

  ex_resolve #(.DW(DW), .RW(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .pc           (pc),
    .br_target    (br_target),
    .br_type      (br_type),
    .aluc         (aluc),
    .alu_r        (alu_r),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .st_data      (st_data),
    .rd           (rd),
    .wreg         (wreg),
    .m2reg        (m2reg),
    .wmem         (wmem),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_r        (out_r),
    .out_st_data  (out_st_data),
    .out_rd       (out_rd),
    .out_wreg     (out_wreg),
    .out_m2reg    (out_m2reg),
    .out_wmem     (out_wmem),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .exc_ovf      (exc_ovf),
    .exc_epc      (exc_epc),
    .exc_ack      (exc_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; pc = '0; br_target = '0; br_type = 3'b000;
    aluc = 4'b0000; alu_r = '0; alu_zero = 1'b0; alu_carry = 1'b0;
    alu_negative = 1'b0; alu_overflow = 1'b0; st_data = '0; rd = '0;
    wreg = 1'b0; m2reg = 1'b0; wmem = 1'b0; exc_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; br_type = 3'b001; alu_zero = 1'b1; br_target = 32'h0040_0080;
    alu_r = 32'hDEAD_BEEF; st_data = 32'h1111_2222; rd = 5'd7; wreg = 1'b1; wmem = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || redirect !== 1'b1) begin
      bad++; $display("FAIL reset_setup: out_valid=%b redirect=%b expected 1 1", out_valid, redirect);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; idle_inputs();
    total++;
    if (out_valid !== 1'b0 || out_r !== '0 || out_st_data !== '0 || out_rd !== '0 ||
        out_wreg !== 1'b0 || out_m2reg !== 1'b0 || out_wmem !== 1'b0) begin
      bad++; $display("FAIL reset_outs: valid=%b r=%h st=%h rd=%0d w=%b%b%b expected all 0",
                      out_valid, out_r, out_st_data, out_rd, out_wreg, out_m2reg, out_wmem);
    end
    total++;
    if (redirect !== 1'b0 || redirect_pc !== '0 || exc_ovf !== 1'b0 || exc_epc !== '0) begin
      bad++; $display("FAIL reset_ctrl: redirect=%b rpc=%h exc=%b epc=%h expected 0", redirect, redirect_pc, exc_ovf, exc_epc);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_beq_bne();
    idle_inputs();
    in_valid = 1'b1; br_type = 3'b001; alu_zero = 1'b1; br_target = 32'h0040_0020;
    step();
    in_valid = 1'b0;
    total++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h0040_0020 || out_valid !== 1'b1) begin
      bad++; $display("FAIL beq_taken: redirect=%b rpc=%h valid=%b expected 1 00400020 1", redirect, redirect_pc, out_valid);
    end
    step();
    total++;
    if (redirect !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL beq_pulse: redirect=%b valid=%b expected 0 0", redirect, out_valid);
    end
    in_valid = 1'b1; br_type = 3'b010; alu_zero = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (redirect !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bne_not_taken: redirect=%b valid=%b expected 0 1", redirect, out_valid);
    end
    step();
  endtask

  task automatic test_branch_sweep();
    logic [2:0] types [3];
    logic [1:0] flags [3];      // {neg, zero}
    logic       exp_tab [9];
    types = '{3'b100, 3'b101, 3'b110};
    flags = '{2'b00, 2'b01, 2'b10};
    exp_tab = '{1'b0, 1'b0, 1'b1,   // bltz
                1'b0, 1'b1, 1'b1,   // blez
                1'b1, 1'b0, 1'b0};  // bgtz
    idle_inputs();
    for (int t = 0; t < 3; t++) begin
      for (int f = 0; f < 3; f++) begin
        in_valid = 1'b1; br_type = types[t];
        alu_negative = flags[f][1]; alu_zero = flags[f][0];
        br_target = 32'h0040_1000 + 32'(t * 16 + f * 4);
        step();
        in_valid = 1'b0;
        total++;
        if (redirect !== exp_tab[t*3+f]) begin
          bad++; $display("FAIL sweep type=%b nz=%b: redirect=%b expected %b", types[t], flags[f], redirect, exp_tab[t*3+f]);
        end
        if (exp_tab[t*3+f]) begin
          total++;
          if (redirect_pc !== 32'h0040_1000 + 32'(t * 16 + f * 4)) begin
            bad++; $display("FAIL sweep_pc type=%b: rpc=%h", types[t], redirect_pc);
          end
        end
        step();
      end
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    out_ready = 1'b1;
    in_valid = 1'b1; alu_r = 32'h1234_5678; rd = 5'd3; wreg = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_r !== 32'h1234_5678) begin
      bad++; $display("FAIL bp_load: valid=%b r=%h expected 1 12345678", out_valid, out_r);
    end
    out_ready = 1'b0; alu_r = 32'hCAFE_F00D; rd = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, in_ready);
      end
      step();
      total++;
      if (out_r !== 32'h1234_5678 || out_rd !== 5'd3 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold cycle %0d: r=%h rd=%0d valid=%b expected 12345678 3 1", c, out_r, out_rd, out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (out_r !== 32'hCAFE_F00D || out_rd !== 5'd9 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_release_load: r=%h rd=%0d valid=%b expected cafef00d 9 1", out_r, out_rd, out_valid);
    end
    step();
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1'b1; flush = 1'b1; br_type = 3'b001; alu_zero = 1'b1;
    br_target = 32'h0040_0444; alu_r = 32'h5555_AAAA; wreg = 1'b1;
    step();
    idle_inputs();
    total++;
    if (out_valid !== 1'b0 || redirect !== 1'b0) begin
      bad++; $display("FAIL flush: valid=%b redirect=%b expected 0 0", out_valid, redirect);
    end
    step();
  endtask

  task automatic test_ovf();
    idle_inputs();
    // unsigned add never traps, even with the overflow flag set
    in_valid = 1'b1; aluc = 4'b0000; alu_overflow = 1'b1; pc = 32'h0040_00F0;
    alu_r = 32'h8000_0000; rd = 5'd4; wreg = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (out_wreg !== 1'b1 || exc_ovf !== 1'b0) begin
      bad++; $display("FAIL addu_no_trap: wreg=%b exc=%b expected 1 0", out_wreg, exc_ovf);
    end
    step();
    in_valid = 1'b1; aluc = 4'b0010; alu_overflow = 1'b1; pc = 32'h0040_0100;
    alu_r = 32'h8000_0001; rd = 5'd5; wreg = 1'b1; wmem = 1'b0; m2reg = 1'b0;
    step();
    in_valid = 1'b0;
`ifdef MIPS246_EXC_OVF_EN
    total++;
    if (exc_ovf !== 1'b1 || exc_epc !== 32'h0040_0100 || out_wreg !== 1'b0 || redirect !== 1'b0) begin
      bad++; $display("FAIL ovf_trap: exc=%b epc=%h wreg=%b redirect=%b expected 1 00400100 0 0", exc_ovf, exc_epc, out_wreg, redirect);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL ovf_in_ready: got %b expected 0", in_ready);
    end
    step();
    step();
    total++;
    if (in_ready !== 1'b0 || exc_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_wait: in_ready=%b exc=%b expected 0 1", in_ready, exc_ovf);
    end
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    total++;
    if (exc_ovf !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL ovf_ack: exc=%b in_ready=%b expected 0 1", exc_ovf, in_ready);
    end
`else
    total++;
    if (out_wreg !== 1'b1 || exc_ovf !== 1'b0 || exc_epc !== '0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL ovf_disabled: wreg=%b exc=%b epc=%h valid=%b expected 1 0 0 1", out_wreg, exc_ovf, exc_epc, out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL ovf_disabled_ready: got %b expected 1", in_ready);
    end
`endif
    step();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; out_ready = 1'b1;
    idle_inputs();
    step();
    step();
    test_reset();
    test_beq_bne();
    test_branch_sweep();
    test_backpressure();
    test_flush();
    test_ovf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
